control_unit: RTL and testbench
===============================

# control_unit

Moore-style FSM sequencer for the 16-bit processor's fetch/decode/execute loop. It sits in the controller next to the instruction register, the 7-bit program counter and the instruction ROM (`iROM`). From the current instruction word it drives:

- program-counter clear and increment;
- instruction-register load;
- data-memory address and write enable;
- register-file addresses, write enable and source select;
- the ALU operation select.

It also exports its current and next state codes for debug display.

## Interface
- No parameters: instruction 16 bits, data address 8 bits, register address 4 bits, ALU select 4 bits, state code 4 bits.
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed).
- IR  in  16  current instruction register contents (loaded externally when IR_LD=1).
- PC_CLR  out  1  clear program counter.
- PC_IC  out  1  increment program counter.
- IR_LD  out  1  load IR from instruction ROM output.
- D_WR  out  1  data memory write enable.
- RF_S  out  1  register-file write-data select: 1 = data memory, 0 = ALU.
- RF_W_EN  out  1  register-file write enable.
- D_ADDR  out  8  data memory address.
- RF_A_ADDR, RF_B_ADDR, RF_W_ADDR  out  4 each  register-file read A, read B, write addresses.
- ALU_S  out  4  ALU operation: 4'd0 pass/none, 4'd1 add (A+B), 4'd2 subtract (A−B).
- CurrentState_Out  out  4  present state code.
- NextState_Out  out  4  combinational next-state code.

## Operation
- States and codes:
  - 0 Init, 1 Fetch, 2 Decode, 3 NoOp
  - 4 LoadA, 5 LoadB, 6 Store, 7 Add, 8 Sub, 9 Halt
  - Codes 10–15 unused; any unused code goes to Init on the next edge.
- Instruction format (opcode = IR[15:12]):
  - 0000 NOOP.
  - 0001 STORE: D[IR[11:4]] ← RF[IR[3:0]].
  - 0010 LOAD: RF[IR[11:8]] ← D[IR[7:0]].
  - 0011 ADD: RF[IR[3:0]] ← RF[IR[11:8]] + RF[IR[7:4]].
  - 0100 SUB: RF[IR[3:0]] ← RF[IR[11:8]] − RF[IR[7:4]].
  - 0101 HALT.
  - 0110–1111 are treated as NOOP.
- Transitions:
  - Init→Fetch, Fetch→Decode.
  - Decode → NoOp / Store / LoadA / Add / Sub / Halt per opcode.
  - LoadA→LoadB; NoOp, LoadB, Store, Add, Sub → Fetch.
  - Halt→Halt until Reset.
- Outputs are functions of state and IR only. Every output not listed for a state is 0.
  - Init: PC_CLR=1.
  - Fetch: IR_LD=1, PC_IC=1.
  - Decode, NoOp, Halt: all 0.
  - LoadA: D_ADDR=IR[7:0], RF_S=1.
  - LoadB: D_ADDR=IR[7:0], RF_S=1, RF_W_ADDR=IR[11:8], RF_W_EN=1.
  - Store: D_ADDR=IR[11:4], RF_A_ADDR=IR[3:0], D_WR=1.
  - Add: RF_A_ADDR=IR[11:8], RF_B_ADDR=IR[7:4], RF_W_ADDR=IR[3:0], ALU_S=1, RF_S=0, RF_W_EN=1.
  - Sub: same as Add with ALU_S=2.
- iROM companion:
  - 128×16 read-only, address 7 bits, input `address`, clock `clock`, output `q`.
  - Address is registered on the rising clock; q = mem[registered address].
  - No reset, no write port.
  - Contents come from the initialization file; unspecified words read 0.

## Timing
- Reset sampled on rising Clock. Reset=1 forces state Init at that edge, overriding any transition, including mid-instruction and from Halt.
- Output values while in Init: PC_CLR=1, all other outputs 0, CurrentState_Out=0, NextState_Out=1.
- Instruction latency from Fetch entry to the next Fetch:
  - NOOP, STORE, ADD, SUB, unused opcodes: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: never returns.
- LOAD needs two execute cycles because data memory is synchronous-read: LoadA presents the address, LoadB writes the register.
- IR is loaded and the PC incremented at the edge ending Fetch. Decode therefore sees the new IR.
- PC is cleared at the edge ending Init, so the first Fetch uses PC=0.
- ROM timing: the ROM latches the PC one edge before each Fetch. Every path from Fetch back to Fetch spans at least 3 cycles, so q equals mem[PC] throughout Fetch.
- PC is 7 bits and wraps from 127 to 0 on increment; the FSM takes no special action.
- NextState_Out always equals the value the state register will take at the next edge when Reset=0.

## Test plan
- Reset then release, ROM all zeros → states 0,1,2,3,1,2,3…; PC_CLR=1 only in Init; PC goes 0,1,2…; IR_LD=PC_IC=1 exactly once per 3 cycles.
- ROM[0]=16'h3012 → in Add: RF_A_ADDR=0, RF_B_ADDR=1, RF_W_ADDR=2, ALU_S=1, RF_W_EN=1, RF_S=0. ROM[1]=16'h4345 → in Sub: A=3, B=4, W=5, ALU_S=2.
- ROM[0]=16'h2A1F → LoadA: D_ADDR=8'h1F, RF_S=1, RF_W_EN=0. LoadB: RF_W_ADDR=4'hA, RF_W_EN=1. Next Fetch 4 cycles after the first.
- ROM[0]=16'h1C53 → Store: D_ADDR=8'hC5, RF_A_ADDR=3, D_WR=1 for exactly one cycle.
- ROM[0]=16'h5000 → state 9 held for 20+ cycles with PC frozen at 1 and all strobes 0. Then assert Reset one cycle → Init, PC=0, execution resumes.
- Assert Reset during LoadA of a LOAD → next state Init, no RF_W_EN pulse. Also: unused opcode 16'hF000 behaves as NOOP.

Source files
------------

// File: rtl/control_unit_if.sv
// Controller bus for the 16-bit processor's sequencer.
//
// Handshake: there is no valid/ready pair on this bus. Every output is a
// Moore strobe that is valid for the whole cycle the FSM spends in a state.
// IR is expected to be stable except at the clock edge where IR_LD=1 is
// acted on, which is the edge ending Fetch.
interface control_unit_if;
  logic [15:0] IR;
  logic        PC_CLR;
  logic        PC_IC;
  logic        IR_LD;
  logic        D_WR;
  logic        RF_S;
  logic        RF_W_EN;
  logic [7:0]  D_ADDR;
  logic [3:0]  RF_A_ADDR;
  logic [3:0]  RF_B_ADDR;
  logic [3:0]  RF_W_ADDR;
  logic [3:0]  ALU_S;
  logic [3:0]  CurrentState_Out;
  logic [3:0]  NextState_Out;

  // Sequencer side: consumes IR, drives all strobes and debug state codes.
  modport master (
    input  IR,
    output PC_CLR, PC_IC, IR_LD, D_WR, RF_S, RF_W_EN, D_ADDR,
    output RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S,
    output CurrentState_Out, NextState_Out
  );

  // Datapath side: supplies IR, obeys the strobes.
  modport slave (
    output IR,
    input  PC_CLR, PC_IC, IR_LD, D_WR, RF_S, RF_W_EN, D_ADDR,
    input  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S,
    input  CurrentState_Out, NextState_Out
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit processor.
// Outputs are registered: each cycle the decode for the state about to be
// entered is captured, so the strobes are glitch-free and line up with the
// state register. IR only changes at the edge ending Fetch, and no state
// entered from Fetch (Decode) depends on IR, so the registered decode always
// sees the same IR the state itself sees.
module control_unit (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic        pc_clr_q, pc_clr_d;
  logic        pc_ic_q, pc_ic_d;
  logic        ir_ld_q, ir_ld_d;
  logic        d_wr_q, d_wr_d;
  logic        rf_s_q, rf_s_d;
  logic        rf_w_en_q, rf_w_en_d;
  logic [7:0]  d_addr_q, d_addr_d;
  logic [3:0]  rf_a_addr_q, rf_a_addr_d;
  logic [3:0]  rf_b_addr_q, rf_b_addr_d;
  logic [3:0]  rf_w_addr_q, rf_w_addr_d;
  logic [3:0]  alu_s_q, alu_s_d;

  // Next-state: opcode dispatch in Decode; unused codes fall back to Init.
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.IR[15:12])
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_LOAD_A;
          4'h3:    state_d = S_ADD;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_HALT;
          default: state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Output decode for the state being entered next.
  always_comb begin
    pc_clr_d    = 1'b0;
    pc_ic_d     = 1'b0;
    ir_ld_d     = 1'b0;
    d_wr_d      = 1'b0;
    rf_s_d      = 1'b0;
    rf_w_en_d   = 1'b0;
    d_addr_d    = 8'h00;
    rf_a_addr_d = 4'h0;
    rf_b_addr_d = 4'h0;
    rf_w_addr_d = 4'h0;
    alu_s_d     = 4'd0;
    case (state_d)
      S_INIT:   pc_clr_d = 1'b1;
      S_FETCH: begin
        ir_ld_d = 1'b1;
        pc_ic_d = 1'b1;
      end
      S_LOAD_A: begin
        d_addr_d = bus.IR[7:0];
        rf_s_d   = 1'b1;
      end
      S_LOAD_B: begin
        d_addr_d    = bus.IR[7:0];
        rf_s_d      = 1'b1;
        rf_w_addr_d = bus.IR[11:8];
        rf_w_en_d   = 1'b1;
      end
      S_STORE: begin
        d_addr_d    = bus.IR[11:4];
        rf_a_addr_d = bus.IR[3:0];
        d_wr_d      = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_a_addr_d = bus.IR[11:8];
        rf_b_addr_d = bus.IR[7:4];
        rf_w_addr_d = bus.IR[3:0];
        alu_s_d     = (state_d == S_ADD) ? 4'd1 : 4'd2;
        rf_w_en_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; Reset lands in Init with its outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_INIT;
      pc_clr_q    <= 1'b1;
      pc_ic_q     <= 1'b0;
      ir_ld_q     <= 1'b0;
      d_wr_q      <= 1'b0;
      rf_s_q      <= 1'b0;
      rf_w_en_q   <= 1'b0;
      d_addr_q    <= 8'h00;
      rf_a_addr_q <= 4'h0;
      rf_b_addr_q <= 4'h0;
      rf_w_addr_q <= 4'h0;
      alu_s_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      pc_clr_q    <= pc_clr_d;
      pc_ic_q     <= pc_ic_d;
      ir_ld_q     <= ir_ld_d;
      d_wr_q      <= d_wr_d;
      rf_s_q      <= rf_s_d;
      rf_w_en_q   <= rf_w_en_d;
      d_addr_q    <= d_addr_d;
      rf_a_addr_q <= rf_a_addr_d;
      rf_b_addr_q <= rf_b_addr_d;
      rf_w_addr_q <= rf_w_addr_d;
      alu_s_q     <= alu_s_d;
    end
  end

  assign bus.PC_CLR           = pc_clr_q;
  assign bus.PC_IC            = pc_ic_q;
  assign bus.IR_LD            = ir_ld_q;
  assign bus.D_WR             = d_wr_q;
  assign bus.RF_S             = rf_s_q;
  assign bus.RF_W_EN          = rf_w_en_q;
  assign bus.D_ADDR           = d_addr_q;
  assign bus.RF_A_ADDR        = rf_a_addr_q;
  assign bus.RF_B_ADDR        = rf_b_addr_q;
  assign bus.RF_W_ADDR        = rf_w_addr_q;
  assign bus.ALU_S            = alu_s_q;
  assign bus.CurrentState_Out = state_q;
  assign bus.NextState_Out    = state_d;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small processor environment (PC, iROM, IR)
// around the sequencer, a trace-level reference model that walks the
// program instruction by instruction, and a per-cycle scoreboard monitor.
module tb_control_unit;

  localparam int W = 45;

  localparam int S_INIT   = 0;
  localparam int S_FETCH  = 1;
  localparam int S_DECODE = 2;
  localparam int S_NOOP   = 3;
  localparam int S_LOAD_A = 4;
  localparam int S_LOAD_B = 5;
  localparam int S_STORE  = 6;
  localparam int S_ADD    = 7;
  localparam int S_SUB    = 8;
  localparam int S_HALT   = 9;

  logic Clock;
  logic Reset;
  logic mon_en;
  logic fin_req;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];

  // Processor environment around the sequencer.
  logic [15:0] rom [128];
  logic [6:0]  pc_q;
  logic [6:0]  rom_addr_q;
  logic [15:0] ir_q;

  control_unit_if bus ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.IR = ir_q;

  // Clock generation.
  always #5 Clock = ~Clock;

  // PC, ROM address register and IR, as the datapath around the controller.
  always @(posedge Clock) begin
    rom_addr_q <= pc_q;
    if (Reset || bus.PC_CLR) pc_q <= 7'd0;
    else if (bus.PC_IC)      pc_q <= pc_q + 7'd1;
    if (bus.IR_LD) ir_q <= rom[rom_addr_q];
  end

  // Expected observable vector for one cycle spent in state s.
  function automatic logic [W-1:0] exp_vec(int s, int nx, logic [15:0] ir,
                                           logic [6:0] pc);
    logic       pc_clr, pc_ic, ir_ld, d_wr, rf_s, rf_w_en;
    logic [7:0] d_addr;
    logic [3:0] ra, rb, rw, alu;
    pc_clr = 0; pc_ic = 0; ir_ld = 0; d_wr = 0; rf_s = 0; rf_w_en = 0;
    d_addr = 0; ra = 0; rb = 0; rw = 0; alu = 0;
    case (s)
      S_INIT:   pc_clr = 1;
      S_FETCH:  begin ir_ld = 1; pc_ic = 1; end
      S_LOAD_A: begin d_addr = ir[7:0]; rf_s = 1; end
      S_LOAD_B: begin d_addr = ir[7:0]; rf_s = 1; rw = ir[11:8]; rf_w_en = 1; end
      S_STORE:  begin d_addr = ir[11:4]; ra = ir[3:0]; d_wr = 1; end
      S_ADD:    begin ra = ir[11:8]; rb = ir[7:4]; rw = ir[3:0]; alu = 1; rf_w_en = 1; end
      S_SUB:    begin ra = ir[11:8]; rb = ir[7:4]; rw = ir[3:0]; alu = 2; rf_w_en = 1; end
      default: ;
    endcase
    return {4'(s), 4'(nx), pc_clr, pc_ic, ir_ld, d_wr, rf_s, rf_w_en,
            d_addr, ra, rb, rw, alu, pc};
  endfunction

  // Reference model: execute the ROM program from reset and queue the
  // expected vector for each of the first n cycles.
  function automatic void gen_trace(int n);
    int          st[$];
    logic [15:0] irs[$];
    logic [6:0]  pcs[$];
    int          steps[$];
    logic [6:0]  pc;
    logic [15:0] ir;
    pc = 7'd0;
    ir = 16'h0;
    st.push_back(S_INIT); irs.push_back(ir); pcs.push_back(pc);
    while (st.size() < n + 1) begin
      st.push_back(S_FETCH); irs.push_back(ir); pcs.push_back(pc);
      ir = rom[pc];
      pc = pc + 7'd1;
      steps.delete();
      steps.push_back(S_DECODE);
      case (ir[15:12])
        4'h1: steps.push_back(S_STORE);
        4'h2: begin steps.push_back(S_LOAD_A); steps.push_back(S_LOAD_B); end
        4'h3: steps.push_back(S_ADD);
        4'h4: steps.push_back(S_SUB);
        4'h5: ;
        default: steps.push_back(S_NOOP);
      endcase
      foreach (steps[k]) begin
        st.push_back(steps[k]); irs.push_back(ir); pcs.push_back(pc);
      end
      if (ir[15:12] == 4'h5) begin
        while (st.size() < n + 1) begin
          st.push_back(S_HALT); irs.push_back(ir); pcs.push_back(pc);
        end
      end
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back(exp_vec(st[i], st[i+1], irs[i], pcs[i]));
  endfunction

  // Scoreboard monitor: one comparison per cycle, sampled on the falling edge.
  always @(negedge Clock) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {bus.CurrentState_Out, bus.NextState_Out, bus.PC_CLR, bus.PC_IC,
           bus.IR_LD, bus.D_WR, bus.RF_S, bus.RF_W_EN, bus.D_ADDR,
           bus.RF_A_ADDR, bus.RF_B_ADDR, bus.RF_W_ADDR, bus.ALU_S, pc_q};
    if (fin_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL queue_drain: actual %0d entries left, required 0", exp_q.size());
      end
    end else if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_underflow: actual=%h required=<none>", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL cycle_check t=%0t state=%0d: actual=%h required=%h",
                   $time, exp[44:41], act, exp);
        end
      end
    end
  end

  // Driver: Reset is high on entry; release it, run n cycles, re-assert it
  // in the last cycle so the following edge returns to Init.
  task automatic run(int n);
    gen_trace(n);
    @(posedge Clock);
    #1 Reset = 1'b0;
    mon_en = 1'b1;
    repeat (n - 1) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    logic [3:0] op;
    Clock   = 1'b0;
    Reset   = 1'b1;
    mon_en  = 1'b0;
    fin_req = 1'b0;
    checks  = 0;
    errors  = 0;

    // All-NOOP program, long enough for the PC to wrap past 127.
    clear_rom();
    run(400);

    // ADD then SUB.
    clear_rom();
    rom[0] = 16'h3012;
    rom[1] = 16'h4345;
    run(12);

    // LOAD: two execute cycles.
    clear_rom();
    rom[0] = 16'h2A1F;
    run(12);

    // Reset arriving in LoadA: next cycle must be Init with no write.
    run(4);
    run(8);

    // STORE.
    clear_rom();
    rom[0] = 16'h1C53;
    run(10);

    // HALT holds with PC frozen at 1, then Reset restarts execution.
    clear_rom();
    rom[0] = 16'h5000;
    run(26);
    rom[0] = 16'h0000;
    run(8);

    // Unused opcode behaves as NOOP.
    clear_rom();
    rom[0] = 16'hF000;
    rom[1] = 16'hA123;
    run(10);

    // Random programs; HALT kept rare so execution runs on.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 128; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h5 && $urandom_range(0, 3) != 0) op = 4'h0;
        rom[i] = {op, 12'($urandom)};
      end
      run($urandom_range(40, 90));
    end

    @(negedge Clock);
    #1;
    mon_en  = 1'b0;
    fin_req = 1'b1;
    @(negedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
